// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, applies MTHI/MTLO at once, and applies mult/div results after a fixed busy time.
// Latency: MTHI/MTLO results are visible the cycle after start; MULT* results after MULT_CYC busy cycles, DIV* results after DIV_CYC busy cycles.
// Backpressure: stall_md holds F/D while a HI/LO user sits in D and the unit is starting or busy; a start seen while busy is dropped.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, lo_q, hi_d, lo_d;
    logic [31:0]   hin_q, lon_q, hin_d, lon_d;

    // Arithmetic is evaluated combinationally on the operands presented at start.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] divisor_u;
    logic signed [31:0] dividend_s, divisor_s;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero or overflowing divisor is replaced by 1 so the dividers never see an undefined case;
    // the real outcome for those cases is chosen in the next-state logic.
    assign div_zero   = (b == 32'd0);
    assign div_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign divisor_u  = div_zero ? 32'd1 : b;
    assign dividend_s = $signed(a);
    assign divisor_s  = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
    assign quo_s      = dividend_s / divisor_s;
    assign rem_s      = dividend_s % divisor_s;
    assign quo_u      = a / divisor_u;
    assign rem_u      = a % divisor_u;

    // Next-state, counter and HI/LO update decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hin_d   = hin_q;
        lon_d   = lon_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            hin_d   = prod_s[63:32];
                            lon_d   = prod_s[31:0];
                            cnt_d   = CW'(MULT_CYC);
                            state_d = BUSY;
                        end
                        OP_MULTU: begin
                            hin_d   = prod_u[63:32];
                            lon_d   = prod_u[31:0];
                            cnt_d   = CW'(MULT_CYC);
                            state_d = BUSY;
                        end
                        OP_DIV: begin
                            if (div_zero) begin
                                hin_d = hi_q;
                                lon_d = lo_q;
                            end else if (div_ovf) begin
                                hin_d = 32'd0;
                                lon_d = 32'h8000_0000;
                            end else begin
                                hin_d = rem_s;
                                lon_d = quo_s;
                            end
                            cnt_d   = CW'(DIV_CYC);
                            state_d = BUSY;
                        end
                        OP_DIVU: begin
                            // Divide by zero keeps HI/LO: the pending result is simply the current value.
                            hin_d   = div_zero ? hi_q : rem_u;
                            lon_d   = div_zero ? lo_q : quo_u;
                            cnt_d   = CW'(DIV_CYC);
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = hin_q;
                    lo_d    = lon_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hin_q   <= 32'd0;
            lon_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hin_q   <= hin_d;
            lon_q   <= lon_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_use_D & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases with literal expectations plus random traffic.
// A behavioural model tracks HI/LO and remaining busy time; one negedge process compares every cycle.
// Inputs are driven 1ns after the rising edge.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_use_D (md_use_D),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: architectural HI/LO, remaining busy cycles and the result waiting to land.
    logic [31:0]     m_hi, m_lo, p_hi, p_lo;
    bit              p_upd;
    int              m_left;
    int              ia, ib;
    longint          sa, sb, pr, q, r;
    longint unsigned ua, ub, pu, qu, ru;

    always @(posedge clk) begin
        if (reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            p_upd  = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && p_upd) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            ia = a;  ib = b;
            sa = ia; sb = ib;
            ua = a;  ub = b;
            case (md_op)
                3'd0: begin pr = sa * sb; p_hi = pr[63:32]; p_lo = pr[31:0]; p_upd = 1'b1; m_left = 5; end
                3'd1: begin pu = ua * ub; p_hi = pu[63:32]; p_lo = pu[31:0]; p_upd = 1'b1; m_left = 5; end
                3'd2: begin
                    m_left = 10;
                    p_upd  = (b != 32'd0);
                    if (p_upd) begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
                3'd3: begin
                    m_left = 10;
                    p_upd  = (b != 32'd0);
                    if (p_upd) begin
                        qu = ua / ub; ru = ua % ub;
                        p_lo = qu[31:0]; p_hi = ru[31:0];
                    end
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("stall_md", {31'd0, stall_md}, {31'd0, md_use_D & (start | (m_left > 0))});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; md_op = op; a = x; b = y;
        cyc(1);
        start = 1'b0; md_op = 3'($urandom_range(7)); a = $urandom; b = $urandom;
    endtask

    // Issue an op and count how many cycles busy stays high afterwards.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int exp_n, input string nm);
        int n;
        issue(op, x, y);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            cyc(1);
        end
        check({nm, " busy cycles"}, n, exp_n);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; md_use_D = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // MTHI / MTLO take effect at the next edge without busy.
        issue(3'd4, 32'h1234, 32'd0);
        check("mthi hi", hi, 32'h1234);
        check("mthi busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        check("mtlo lo", lo, 32'h5678);
        check("mtlo hi kept", hi, 32'h1234);

        // MULT -2*3 with a HI/LO user waiting in D.
        md_use_D = 1'b1;
        start = 1'b1; md_op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3;
        #1;
        check("stall in start cycle", {31'd0, stall_md}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        check("hi held while busy", hi, 32'h1234);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            check("stall while busy", {31'd0, stall_md}, 32'd1);
            n++;
            cyc(1);
        end
        check("mult busy cycles", n, 5);
        check("stall at completion", {31'd0, stall_md}, 32'd0);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFFA);
        md_use_D = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu");
        check("multu hi", hi, 32'hFFFF_FFFE);
        check("multu lo", lo, 32'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, "div -7/2");
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div ovf");
        check("div ovf lo", lo, 32'h8000_0000);
        check("div ovf hi", hi, 32'd0);

        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        run_op(3'd2, 32'h1234, 32'd0, 10, "div by zero");
        check("div0 hi kept", hi, 32'h11);
        check("div0 lo kept", lo, 32'h22);
        run_op(3'd3, 32'd5, 32'd0, 10, "divu by zero");
        check("divu0 hi kept", hi, 32'h11);
        check("divu0 lo kept", lo, 32'h22);

        // A start pulse while busy must not disturb the in-flight MULT.
        issue(3'd0, 32'd3, 32'd4);
        cyc(2);
        start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
        cyc(1);
        start = 1'b0;
        n = 3;
        while (busy === 1'b1 && n < 100) begin
            n++;
            cyc(1);
        end
        check("ignored start busy cycles", n, 5);
        check("ignored start lo", lo, 32'd12);
        check("ignored start hi", hi, 32'd0);

        // Reset for two cycles while a DIV has 4 cycles left.
        issue(3'd2, 32'd1000, 32'd3);
        cyc(6);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("mid-op reset busy", {31'd0, busy}, 32'd0);
        check("mid-op reset hi", hi, 32'd0);
        check("mid-op reset lo", lo, 32'd0);
        run_op(3'd0, 32'd7, 32'd6, 5, "mult after reset");
        check("mult after reset lo", lo, 32'd42);

        // Random traffic, including starts during busy and occasional resets.
        repeat (1500) begin
            reset    = ($urandom_range(99) == 0);
            md_use_D = $urandom_range(1);
            start    = ($urandom_range(2) == 0);
            md_op    = 3'($urandom_range(7));
            a        = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(9));
                default: b = $urandom;
            endcase
            cyc(1);
        end
        reset = 1'b0; start = 1'b0; md_use_D = 1'b0;
        cyc(12);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit sequencer in the E stage of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E and owns the HI/LO registers.
- Models the fixed multi-cycle latency with a busy counter.
- Produces the D-stage stall for any HI/LO-touching instruction while the unit is occupied; the hazard unit ORs this into its global stall.

Parameters:
- MULT_CYC, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYC, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is an MDU operation; valid for one cycle.
- md_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; other codes are ignored.
- a  input  32  forwarded rs value from E.
- b  input  32  forwarded rt value from E.
- md_use_D  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.
- stall_md  output  1  stall request for the F/D stages.

Behaviour:
- Reset, taking effect at the next rising edge, including mid-operation:
  - state=IDLE, counter=0, hi=0, lo=0, busy=0.
  - The pending result is discarded.
- States: IDLE, BUSY.
- IDLE, start=1, md_op in 0..3:
  - Latch a, b, md_op.
  - Compute the result into internal hi_n/lo_n; the arithmetic may be combinational at latch time.
  - counter := MULT_CYC or DIV_CYC; go to BUSY.
- IDLE, start=1, md_op 4 or 5:
  - hi:=a (MTHI) or lo:=a (MTLO) at that edge.
  - Stay in IDLE; busy stays 0.
- IDLE, start=1, md_op 6/7: no effect.
- BUSY:
  - counter decrements each edge.
  - At the edge where counter==1: hi:=hi_n, lo:=lo_n, go to IDLE.
- Latency and timing (start high in cycle T):
  - busy=1 in cycles T+1..T+N (N = MULT_CYC or DIV_CYC).
  - New hi/lo are visible in cycle T+N+1, and busy=0 in that cycle.
  - hi/lo hold their old values throughout BUSY.
- start while BUSY: ignored; the state and in-flight result are unaffected. A protocol violation, prevented by stall_md.
- busy is a registered output, high exactly when state=BUSY.
- stall_md = md_use_D & (start | busy). Purely combinational; asserts in the same cycle start is seen.
- Arithmetic:
  - MULT: {hi,lo} = signed a × signed b, 64-bit two's complement.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder, sign of dividend a.
  - DIV overflow, a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient to lo, remainder to hi.
  - Divide by zero (b=0), DIV or DIVU: the full DIV_CYC busy period still occurs; hi and lo are left unchanged at completion.
- MTHI/MTLO issued the cycle after a multi-cycle op completes (busy just dropped) act normally.
- Because stall_md is raised, no start can coincide with completion.

Test Plan:
- Reset behaviour: reset high for 2 cycles mid-DIV (counter=4) -> next cycle busy=0, hi=0, lo=0; a subsequent MULT starts normally.
- MULT latency: MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged while busy.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV signs and special cases:
  - a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - b=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 retained.
- Stall interaction: MULT start with md_use_D=1 -> stall_md=1 in the start cycle and all 5 busy cycles; 0 in the completion cycle. With md_use_D=0 -> stall_md=0 throughout. A start pulse during BUSY is ignored: result and timing unchanged.
- MTHI/MTLO: MTHI a=0x1234 -> hi=0x1234 the next cycle, busy never asserts; then MTLO a=0x5678 -> lo=0x5678, hi retained.
